// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, parity modes,
// tick-divider and majority-vote helpers.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int calc_div(input int clock_freq,
                                    input int baud_rate,
                                    input int oversample);
        return clock_freq / (baud_rate * oversample);
    endfunction

    function automatic logic majority(input logic a,
                                      input logic b,
                                      input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Ports: push/wdata write, pop reads rdata (head), full, empty, count.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a show-ahead receive FIFO.
// Ports: serial_in line; data_out* head entry with error flags,
// data_out_valid/ready pop handshake, sticky overrun, fifo_count.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000,
    parameter int OVERSAMPLE = 10,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          serial_in,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          data_out_parity_err,
    output logic                          data_out_frame_err,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic                          overrun,
    input  logic                          clear_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int DCW = $clog2(DIV + 1);
    localparam int TCW = $clog2(OVERSAMPLE + 1);
    localparam int WW  = DATA_BITS + 2;

    localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
    localparam logic [TCW-1:0] T_LAST    = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0] T_S0      = TCW'(M - 1);
    localparam logic [TCW-1:0] T_S1      = TCW'(M);
    localparam logic [TCW-1:0] T_S2      = TCW'(M + 1);
    localparam logic [3:0]     BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

    logic                 sync1;
    logic                 rx;
    logic [2:0]           state;
    logic [DCW-1:0]       div_cnt;
    logic [TCW-1:0]       tick_cnt;
    logic [TCW-1:0]       hi_cnt;
    logic                 armed;
    logic [1:0]           smp;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;

    logic                 div_run;
    logic                 tick;
    logic                 mid;
    logic                 bit_end;
    logic                 vote;
    logic                 exp_par;
    logic                 push;
    logic [WW-1:0]        wdata;
    logic [WW-1:0]        rdata;
    logic                 full;
    logic                 empty;
    logic                 pop;

    // While disarmed the divider keeps running so high ticks can be counted.
    assign div_run = (state != ST_IDLE) || !armed;
    assign tick    = div_run && (div_cnt == DIV_LAST);
    assign mid     = tick && (tick_cnt == T_S2);
    assign bit_end = tick && (tick_cnt == T_LAST);
    assign vote    = majority(smp[0], smp[1], rx);
    assign exp_par = (PARITY == PARITY_ODD) ? ~^shreg : ^shreg;
    assign push    = (state == ST_STOP) && mid && (stop_cnt == STOP_LAST);
    assign wdata   = {ferr | ~vote, perr, shreg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= serial_in;
            rx    <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            tick_cnt <= '0;
            hi_cnt   <= '0;
            armed    <= 1'b0;
            smp      <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            div_cnt <= (!div_run || tick) ? '0 : div_cnt + DCW'(1);

            if (state == ST_IDLE && armed)
                tick_cnt <= '0;
            else if (tick)
                tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TCW'(1);

            if (!armed && tick) begin
                if (!rx) begin
                    hi_cnt <= '0;
                end else if (hi_cnt == T_LAST) begin
                    hi_cnt <= '0;
                    armed  <= 1'b1;
                end else begin
                    hi_cnt <= hi_cnt + TCW'(1);
                end
            end
            // A framing error may be a break: demand a fresh idle run.
            if (push && wdata[WW-1])
                armed <= 1'b0;

            if (tick && tick_cnt == T_S0) smp[0] <= rx;
            if (tick && tick_cnt == T_S1) smp[1] <= rx;

            case (state)
                ST_IDLE: begin
                    if (armed && !rx) begin
                        state    <= ST_START;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (mid && vote)
                        state <= ST_IDLE;
                    else if (bit_end)
                        state <= ST_DATA;
                end
                ST_DATA: begin
                    if (mid)
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST)
                            state <= (PARITY != PARITY_NONE) ?
                                     ST_PARITY : ST_STOP;
                        else
                            bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (mid)
                        perr <= (vote != exp_par);
                    if (bit_end)
                        state <= ST_STOP;
                end
                ST_STOP: begin
                    if (mid) begin
                        ferr <= ferr | ~vote;
                        if (stop_cnt == STOP_LAST)
                            state <= ST_IDLE;
                    end
                    if (bit_end)
                        stop_cnt <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pop = data_out_valid && data_out_ready;

    uart_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign data_out            = rdata[DATA_BITS-1:0];
    assign data_out_parity_err = rdata[DATA_BITS];
    assign data_out_frame_err  = rdata[DATA_BITS+1];
    assign data_out_valid      = !empty;

    // Overrun wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (push && full && !pop)
            overrun <= 1'b1;
        else if (clear_overrun)
            overrun <= 1'b0;
    end

endmodule
